// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO: holds {instr, pc} pairs from fetch and presents them in order to decode,
// tagging each entry with an instruction-fetch exception flag computed when the pair is accepted.
module if_id_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_BYTES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pc8,
  output logic                       out_exc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  // 33-bit bounds so IM_BASE + IM_BYTES never wraps
  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + 33'(IM_BYTES);

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;

  logic [31:0] r_instr_mem [DEPTH];
  logic [31:0] r_pc_mem    [DEPTH];
  logic        r_exc_mem   [DEPTH];

  logic        w_push;
  logic        w_pop;
  logic        w_wr_en;
  logic        w_not_empty;
  logic        w_in_exc;
  logic [32:0] w_pc_ext;
  logic [31:0] w_head_instr;
  logic [31:0] w_head_pc;
  logic        w_head_exc;

  assign w_not_empty = (r_count != '0);
  assign in_ready    = (r_count < FULL_C);
  assign out_valid   = w_not_empty;
  assign count       = r_count;

  assign w_push  = in_valid & in_ready;
  assign w_pop   = w_not_empty & out_ready;
  // Flush and reset discard any transfer offered in the same cycle
  assign w_wr_en = w_push & reset & ~flush;

  assign w_pc_ext = {1'b0, in_pc};
  assign w_in_exc = (in_pc[1:0] != 2'b00) | (w_pc_ext < IM_LO) | (w_pc_ext >= IM_HI);

  // Storage carries no reset; only the pointers and count define what is held
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_wr_en && (r_wr_ptr == PW'(gi))) begin
          r_instr_mem[gi] <= w_in_exc ? 32'h0 : in_instr;
          r_pc_mem[gi]    <= in_pc;
          r_exc_mem[gi]   <= w_in_exc;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head_instr = r_instr_mem[r_rd_ptr];
  assign w_head_pc    = r_pc_mem[r_rd_ptr];
  assign w_head_exc   = r_exc_mem[r_rd_ptr];

  // Outputs read as zero whenever nothing is held
  assign out_instr = (w_not_empty && !w_head_exc) ? w_head_instr : 32'h0;
  assign out_pc    = w_not_empty ? w_head_pc : 32'h0;
  assign out_pc8   = w_not_empty ? (w_head_pc + 32'd8) : 32'h0;
  assign out_exc   = w_not_empty & w_head_exc;

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed scenarios plus random traffic, scored against a queue model
// fed at the clock edge and compared by a separate negedge monitor.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_exc;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, out_pc8;
  logic [1:0]  count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mdl_push, mdl_pop;

  always #5 clk = ~clk;

  if_id_buffer #(.DEPTH(2), .IM_BASE(32'h0000_3000), .IM_BYTES(4096)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc8(out_pc8), .out_exc(out_exc), .count(count)
  );

  function automatic exp_t mk(logic [31:0] instr, logic [31:0] pc);
    exp_t e;
    longint unsigned p;
    p       = longint'(pc);
    e.exc   = (p % 4 != 0) || (p < 64'h3000) || (p >= 64'h3000 + 64'd4096);
    e.instr = e.exc ? 32'h0 : instr;
    e.pc    = pc;
    e.pc8   = pc + 32'd8;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of expected entries, updated from the pre-edge inputs
  always @(posedge clk) begin
    if (!reset || flush) begin
      sb.delete();
    end else begin
      mdl_push = in_valid && (sb.size() < 2);
      mdl_pop  = out_ready && (sb.size() > 0);
      if (mdl_pop) void'(sb.pop_front());
      if (mdl_push) begin
        sb.push_back(mk(in_instr, in_pc));
        $display("push pc=%h instr=%h", in_pc, in_instr);
      end
    end
  end

  // Monitor: compares presented head and occupancy against the model
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(sb.size()));
    chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("out_instr", out_instr, sb[0].instr);
      chk("out_pc", out_pc, sb[0].pc);
      chk("out_pc8", out_pc8, sb[0].pc8);
      chk("out_exc", 32'(out_exc), 32'(sb[0].exc));
      if (out_ready && reset && !flush)
        $display("pop  pc=%h instr=%h exc=%0d", out_pc, out_instr, out_exc);
    end else begin
      chk("empty_instr", out_instr, 32'h0);
      chk("empty_pc", out_pc, 32'h0);
      chk("empty_pc8", out_pc8, 32'h0);
      chk("empty_exc", 32'(out_exc), 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  logic [31:0] exc_pcs [5];
  logic        exc_exp [5];

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'hDEAD_BEEF; in_pc = 32'h3000;

    // Reset held with traffic offered
    step(); step();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    reset = 1'b1; in_valid = 1'b0;
    step();

    // Single-entry latency
    out_ready = 1'b1;
    offer(32'h3C01_1234, 32'h3000);
    step();
    in_valid = 1'b0;
    chk("lat_valid", 32'(out_valid), 32'h1);
    chk("lat_instr", out_instr, 32'h3C01_1234);
    chk("lat_pc8", out_pc8, 32'h3008);
    step();
    chk("lat_drained", 32'(out_valid), 32'h0);

    // Fill, stall, then release
    out_ready = 1'b0;
    offer(32'h1111_0000, 32'h3000); step();
    offer(32'h1111_0004, 32'h3004); step();
    chk("full_count", 32'(count), 32'h2);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    offer(32'h1111_0008, 32'h3008); step();
    chk("full_refused_pc", out_pc, 32'h3000);
    out_ready = 1'b1;
    step();
    chk("stall_pop2", out_pc, 32'h3004);
    step();
    in_valid = 1'b0;
    chk("stall_pop3", out_pc, 32'h3008);
    step(); step();

    // Simultaneous push/pop across pointer wrap
    out_ready = 1'b0;
    offer(32'h2222_3000, 32'h3000); step();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      offer(32'h2222_0000 + 32'(i), 32'h3000 + 32'(4 * i));
      step();
      chk("sim_count", 32'(count), 32'h1);
      chk("sim_pc", out_pc, 32'h3000 + 32'(4 * i));
    end
    in_valid = 1'b0; step(); step();

    // Flush drops held entries and the pair offered alongside it
    out_ready = 1'b0;
    offer(32'h3333_0000, 32'h3000); step();
    offer(32'h3333_0004, 32'h3004); step();
    offer(32'h3333_0ABC, 32'h3ABC); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    offer(32'h3333_0040, 32'h3040); step();
    in_valid = 1'b0;
    chk("flush_after_pc", out_pc, 32'h3040);
    chk("flush_after_count", 32'(count), 32'h1);
    out_ready = 1'b1; step(); step();

    // Fetch exception boundaries
    exc_pcs[0] = 32'h3002;    exc_exp[0] = 1'b1;
    exc_pcs[1] = 32'h4000;    exc_exp[1] = 1'b1;
    exc_pcs[2] = 32'h2FFC;    exc_exp[2] = 1'b1;
    exc_pcs[3] = 32'h3FFC;    exc_exp[3] = 1'b0;
    exc_pcs[4] = 32'hFFFF_FFFC; exc_exp[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(32'hABCD_0000 + 32'(i), exc_pcs[i]); step();
      in_valid = 1'b0;
      chk("exc_flag", 32'(out_exc), 32'(exc_exp[i]));
      chk("exc_instr", out_instr, exc_exp[i] ? 32'h0 : 32'hABCD_0000 + 32'(i));
      if (i == 4) chk("pc8_wrap", out_pc8, 32'h0000_0004);
      step();
    end

    // Random traffic with occasional flush and mid-run reset
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 63) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      if ($urandom_range(0, 3) == 0) in_pc = $urandom;
      else in_pc = 32'h3000 + 32'($urandom_range(0, 1023) * 4);
      step();
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
